// File: rtl/btc_enc_spc_encode.sv
// Serial SPC row/column encoder: k info bits in, k bits plus one even-parity bit out.
// Optional BTC_ENC_SPC_SOP_CHECK_EN adds oerr for misplaced sop/eof strobes.
package btc_enc_spc_pkg;

  typedef logic [2:0] btc_code_mode_t;

  typedef struct packed {
    logic sof;
    logic sop;
    logic eop;
    logic eof;
    logic mask;
  } strb_t;

  function automatic logic [6:0] get_code_bits(btc_code_mode_t m);
    logic [6:0] n;
    case (m)
      3'd0:    n = 7'd2;
      3'd1:    n = 7'd4;
      3'd2:    n = 7'd8;
      3'd3:    n = 7'd16;
      3'd4:    n = 7'd32;
      3'd5:    n = 7'd64;
      default: n = 7'd8;
    endcase
    return n;
  endfunction

endpackage

module btc_enc_spc_encode
  import btc_enc_spc_pkg::*;
#(
  parameter int pIDX_W = 6
) (
  input  logic           iclk,
  input  logic           ireset,
  input  logic           iclkena,
  input  btc_code_mode_t imode,
  input  logic           ival,
  input  strb_t          istrb,
  input  logic           idat,
  output logic           ordy,
  output logic           oval,
  output strb_t          ostrb,
  output logic           odat,
  output logic           obusy
`ifdef BTC_ENC_SPC_SOP_CHECK_EN
  ,
  output logic           oerr
`endif
);

  localparam logic [1:0] cIDLE_STATE = 2'd0;
  localparam logic [1:0] cDATA_STATE = 2'd1;
  localparam logic [1:0] cPAR_STATE  = 2'd2;

  logic [1:0]        state;
  logic [1:0]        nxt;
  logic [pIDX_W-1:0] cnt;
  logic [pIDX_W-1:0] cnt_inc;
  logic [pIDX_W-1:0] kinfo_m1;
  logic [pIDX_W-1:0] kinfo_new;
  logic              parity;
  logic              mask_r;
  logic              eof_r;
  logic              acc;
  logic              start;
  logic              data_acc;
  logic              last;
  logic              unused_eop;

  assign unused_eop = istrb.eop;

  assign acc       = ival & ordy;
  assign kinfo_new = pIDX_W'(get_code_bits(imode) - 7'd2);
  assign cnt_inc   = cnt + 1'b1;

`ifdef BTC_ENC_SPC_SOP_CHECK_EN
  assign start = acc & istrb.sop &
                 ((state == cIDLE_STATE) | (state == cDATA_STATE));
`else
  assign start = acc & istrb.sop & (state == cIDLE_STATE);
`endif

  assign data_acc = acc & ~start & (state == cDATA_STATE);

  // a fresh sop is also the last info bit when k = 1
  assign last = start ? (kinfo_new == '0) : (cnt_inc == kinfo_m1);

  always_comb begin
    nxt = state;
    unique case (1'b1)
      (state == cPAR_STATE): nxt = cIDLE_STATE;
      (start | data_acc):    nxt = last ? cPAR_STATE : cDATA_STATE;
      default:               nxt = state;
    endcase
  end

  always_ff @(posedge iclk or negedge ireset) begin
    if (!ireset) begin
      state    <= cIDLE_STATE;
      ordy     <= 1'b1;
      oval     <= 1'b0;
      ostrb    <= '0;
      odat     <= 1'b0;
      obusy    <= 1'b0;
      cnt      <= '0;
      kinfo_m1 <= '0;
      parity   <= 1'b0;
      mask_r   <= 1'b0;
      eof_r    <= 1'b0;
    end else if (iclkena) begin
      state <= nxt;
      ordy  <= (nxt != cPAR_STATE);
      obusy <= (nxt != cIDLE_STATE) | (state == cPAR_STATE);
      oval  <= 1'b0;
      ostrb <= '0;
      if (start) begin
        kinfo_m1   <= kinfo_new;
        mask_r     <= istrb.mask;
        cnt        <= '0;
        parity     <= idat;
        oval       <= 1'b1;
        odat       <= idat;
        ostrb.sop  <= 1'b1;
        ostrb.sof  <= istrb.sof;
        ostrb.mask <= istrb.mask;
        if (last) eof_r <= istrb.eof;
      end else if (data_acc) begin
        cnt        <= cnt_inc;
        parity     <= parity ^ idat;
        oval       <= 1'b1;
        odat       <= idat;
        ostrb.mask <= mask_r;
        if (last) eof_r <= istrb.eof;
      end else if (state == cPAR_STATE) begin
        oval       <= 1'b1;
        odat       <= parity;
        ostrb.eop  <= 1'b1;
        ostrb.eof  <= eof_r;
        ostrb.mask <= mask_r;
      end
    end
  end

`ifdef BTC_ENC_SPC_SOP_CHECK_EN
  always_ff @(posedge iclk or negedge ireset) begin
    if (!ireset) begin
      oerr <= 1'b0;
    end else if (iclkena) begin
      oerr <= (start & (state == cDATA_STATE)) |
              (acc & istrb.eof & ~last);
    end
  end
`endif

endmodule

// File: tb/tb_btc_enc_spc_encode.sv
// Scoreboard bench for btc_enc_spc_encode: driver queues expected code
// word bits, a monitor pops and compares them on every fresh output.
module tb_btc_enc_spc_encode;
  import btc_enc_spc_pkg::*;

  logic           iclk = 1'b0;
  logic           ireset = 1'b0;
  logic           iclkena = 1'b1;
  btc_code_mode_t imode = '0;
  logic           ival = 1'b0;
  strb_t          istrb = '0;
  logic           idat = 1'b0;
  logic           ordy;
  logic           oval;
  strb_t          ostrb;
  logic           odat;
  logic           obusy;
`ifdef BTC_ENC_SPC_SOP_CHECK_EN
  logic           oerr;
`endif

  btc_enc_spc_encode #(.pIDX_W(6)) dut (
    .iclk    (iclk),
    .ireset  (ireset),
    .iclkena (iclkena),
    .imode   (imode),
    .ival    (ival),
    .istrb   (istrb),
    .idat    (idat),
    .ordy    (ordy),
    .oval    (oval),
    .ostrb   (ostrb),
    .odat    (odat),
    .obusy   (obusy)
`ifdef BTC_ENC_SPC_SOP_CHECK_EN
    ,
    .oerr    (oerr)
`endif
  );

  always #5 iclk = ~iclk;

  typedef struct packed {
    logic  d;
    strb_t s;
  } exp_t;

  exp_t q[$];
  int   n_chk = 0;
  int   n_fail = 0;
  int   stalls = 0;
  int   run = 0;
  int   max_run = 0;
  int   errs = 0;
  logic en_q = 1'b0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // monitor: an output is fresh only after an enabled clock edge
  initial begin
    exp_t e;
    forever begin
      @(posedge iclk);
      en_q = iclkena & ireset;
      @(negedge iclk);
      if (en_q && oval) begin
        run++;
        if (run > max_run) max_run = run;
        if (q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL spurious_out: got odat %0b strb %0h expected none",
                   odat, ostrb);
        end else begin
          e = q.pop_front();
          check("out_bit", {26'd0, odat, ostrb}, {26'd0, e.d, e.s});
        end
      end else begin
        run = 0;
      end
`ifdef BTC_ENC_SPC_SOP_CHECK_EN
      if (en_q && oerr) errs++;
`endif
    end
  end

  task automatic push(input logic d, input logic sof, input logic sop,
                      input logic eop, input logic eof, input logic mask);
    exp_t e;
    e.d = d;
    e.s = '0;
    e.s.sof = sof;
    e.s.sop = sop;
    e.s.eop = eop;
    e.s.eof = eof;
    e.s.mask = mask;
    q.push_back(e);
  endtask

  // called at a negedge; returns at the negedge after acceptance
  task automatic put(input logic d, input logic sop, input logic sof,
                     input logic eof, input logic mask,
                     input btc_code_mode_t m);
    ival = 1'b1;
    idat = d;
    istrb.sof = sof;
    istrb.sop = sop;
    istrb.eop = ~d;
    istrb.eof = eof;
    istrb.mask = mask;
    imode = m;
    for (int t = 0; t < 20; t++) begin
      if (ordy && iclkena) begin
        @(negedge iclk);
        return;
      end
      if (!ordy) stalls++;
      @(negedge iclk);
    end
    n_chk++;
    n_fail++;
    $display("FAIL put_timeout: got no ordy expected ordy within 20 cycles");
  endtask

  task automatic word(input btc_code_mode_t m, input int k,
                      input logic [63:0] bits, input logic par,
                      input logic sof, input logic eof, input logic mask,
                      input logic [63:0] gap, input logic [63:0] cgap);
    logic b;
    for (int i = 0; i < k; i++) begin
      b = bits[k-1-i];
      push(b, sof && i == 0, i == 0, 1'b0, 1'b0, mask);
      put(b, i == 0, sof && i == 0, eof && i == k - 1,
          (i == 0) ? mask : ~mask, (i == 0) ? m : ~m);
      if (gap[i]) begin
        ival = 1'b0;
        @(negedge iclk);
      end
      if (cgap[i]) begin
        ival = 1'b0;
        iclkena = 1'b0;
        repeat (3) @(negedge iclk);
        iclkena = 1'b1;
      end
    end
    push(par, 1'b0, 1'b0, 1'b1, eof, mask);
  endtask

  task automatic idle(input int c);
    ival = 1'b0;
    istrb = '0;
    repeat (c) @(negedge iclk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish by 200us");
    $fatal(1);
  end

  initial begin
    repeat (2) @(negedge iclk);
    check("rst_ordy", {31'd0, ordy}, 32'd1);
    check("rst_oval", {31'd0, oval}, 32'd0);
    check("rst_ostrb", {27'd0, ostrb}, 32'd0);
    check("rst_odat", {31'd0, odat}, 32'd0);
    check("rst_obusy", {31'd0, obusy}, 32'd0);
    ireset = 1'b1;
    @(negedge iclk);

    // non-sop bit in idle is dropped
    put(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd2);
    idle(2);

    // n = 8, continuous
    stalls = 0;
    word(3'd2, 7, 64'b1011001, 1'b0, 1'b0, 1'b0, 1'b1, '0, '0);
    check("t1_ordy_low", {31'd0, ordy}, 32'd0);
    idle(1);
    check("t1_ordy_back", {31'd0, ordy}, 32'd1);
    check("t1_busy_par", {31'd0, obusy}, 32'd1);
    idle(1);
    check("t1_busy_end", {31'd0, obusy}, 32'd0);
    idle(2);

    // ival gaps after bits 2 and 5
    word(3'd2, 7, 64'b1110000, 1'b1, 1'b0, 1'b0, 1'b0, 64'h12, '0);
    idle(3);

    // clock-enable gaps after bits 1 and 3
    word(3'd2, 7, 64'b0100110, 1'b1, 1'b0, 1'b0, 1'b1, '0, 64'h5);
    idle(3);

    // three back-to-back words
    max_run = 0;
    stalls = 0;
    word(3'd2, 7, 64'b1011001, 1'b0, 1'b1, 1'b0, 1'b0, '0, '0);
    word(3'd2, 7, 64'b1110000, 1'b1, 1'b0, 1'b0, 1'b0, '0, '0);
    word(3'd2, 7, 64'b0000001, 1'b1, 1'b0, 1'b1, 1'b0, '0, '0);
    check("t3_ordy_low", {31'd0, ordy}, 32'd0);
    idle(3);
    check("t3_stalls", stalls, 32'd2);
    check("t3_run", max_run, 32'd24);

    // n = 2
    word(3'd0, 1, 64'b1, 1'b1, 1'b0, 1'b0, 1'b1, '0, '0);
    check("t4_ordy_low", {31'd0, ordy}, 32'd0);
    idle(1);
    check("t4_ordy_back", {31'd0, ordy}, 32'd1);
    idle(2);

    // reset in the middle of a word
    push(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    put(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'd2);
    push(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    put(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd2);
    push(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    put(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 3'd2);
    push(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    put(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 3'd2);
    idle(1);
    ireset = 1'b0;
    #1;
    check("t5_ordy", {31'd0, ordy}, 32'd1);
    check("t5_oval", {31'd0, oval}, 32'd0);
    check("t5_ostrb", {27'd0, ostrb}, 32'd0);
    check("t5_odat", {31'd0, odat}, 32'd0);
    check("t5_obusy", {31'd0, obusy}, 32'd0);
    repeat (2) @(negedge iclk);
    ireset = 1'b1;
    check("t5_no_pending", q.size(), 32'd0);
    @(negedge iclk);
    word(3'd2, 7, 64'b0110100, 1'b1, 1'b1, 1'b1, 1'b0, '0, '0);
    idle(3);

`ifdef BTC_ENC_SPC_SOP_CHECK_EN
    // sop re-issued at bit 3 restarts the word
    errs = 0;
    push(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    put(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'd2);
    push(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    put(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd2);
    push(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    put(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd2);
    word(3'd2, 7, 64'b1001011, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
    idle(3);
    check("t6_oerr_pulses", errs, 32'd1);
`endif

    idle(4);
    check("queue_drained", q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
